// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM model controller and its clients.
package dram_pkg;

  localparam logic [63:0] BASE_ADDR_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    ERROR = 2'b11
  } dram_state_e;

  typedef enum logic [2:0] {
    RD_NONE = 3'b000,
    RD_LB   = 3'b001,
    RD_LBU  = 3'b010,
    RD_LH   = 3'b011,
    RD_LHU  = 3'b100,
    RD_LW   = 3'b101,
    RD_LD   = 3'b110,
    RD_RSVD = 3'b111
  } rd_op_e;

  typedef enum logic [2:0] {
    WR_NONE  = 3'b000,
    WR_SB    = 3'b001,
    WR_SH    = 3'b010,
    WR_SW    = 3'b011,
    WR_SD    = 3'b100,
    WR_RSVD5 = 3'b101,
    WR_RSVD6 = 3'b110,
    WR_RSVD7 = 3'b111
  } wr_op_e;

  // log2 of the access size in bytes
  function automatic logic [1:0] rd_size_log2(input rd_op_e op);
    case (op)
      RD_LB, RD_LBU: return 2'd0;
      RD_LH, RD_LHU: return 2'd1;
      RD_LW:         return 2'd2;
      default:       return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] wr_size_log2(input wr_op_e op);
    case (op)
      WR_SB:   return 2'd0;
      WR_SH:   return 2'd1;
      WR_SW:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] sl);
    case (sl)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] align_mask(input logic [1:0] sl);
    return 3'((4'd1 << sl) - 4'd1);
  endfunction

endpackage

// File: rtl/dram_array.sv
// Single-port DEPTH x 64 storage: byte-enabled synchronous write, combinational read.
module dram_array #(
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [7:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dram_ctrl.sv
// Fixed-latency DRAM model controller: request checking, busy timing, lane
// extraction/extension on reads and byte-enabled writes.
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned LATENCY   = 4,
  parameter logic [63:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dram_addr,
  input  logic [63:0] dram_din,
  input  logic [2:0]  dram_rd_ctrl,
  input  logic [2:0]  dram_wr_ctrl,
  output logic [63:0] dram_dout,
  output logic [1:0]  state
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  dram_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      addr_q, addr_d;
  logic [63:0]      din_q, din_d;
  rd_op_e           rd_q, rd_d;
  wr_op_e           wr_q, wr_d;
  logic [63:0]      dout_q, dout_d;

  rd_op_e      rd_in;
  wr_op_e      wr_in;
  logic        req;
  logic        req_err;
  logic [1:0]  req_sl;
  logic [63:0] req_off;

  logic             arr_we;
  logic [7:0]       arr_be;
  logic [IDX_W-1:0] arr_idx;
  logic [63:0]      arr_wdata;
  logic [63:0]      arr_rdata;
  logic [63:0]      rd_shift;
  logic [63:0]      rd_result;

  assign rd_in   = rd_op_e'(dram_rd_ctrl);
  assign wr_in   = wr_op_e'(dram_wr_ctrl);
  assign req     = (rd_in != RD_NONE) || (wr_in != WR_NONE);
  assign req_sl  = (rd_in != RD_NONE) ? rd_size_log2(rd_in) : wr_size_log2(wr_in);
  assign req_off = dram_addr - BASE_ADDR;

  // Any of these sends the request to ERROR instead of an array access
  assign req_err = ((rd_in != RD_NONE) && (wr_in != WR_NONE))
                || (rd_in == RD_RSVD)
                || (wr_in == WR_RSVD5) || (wr_in == WR_RSVD6) || (wr_in == WR_RSVD7)
                || ((dram_addr[2:0] & align_mask(req_sl)) != 3'b000)
                || (dram_addr < BASE_ADDR)
                || ((req_off >> 3) >= 64'(DEPTH));

  assign arr_idx   = IDX_W'((addr_q - BASE_ADDR) >> 3);
  assign arr_be    = size_mask(wr_size_log2(wr_q)) << addr_q[2:0];
  assign arr_wdata = din_q << {addr_q[2:0], 3'b000};
  assign rd_shift  = arr_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    rd_result = rd_shift;
    case (rd_q)
      RD_LB:   rd_result = {{56{rd_shift[7]}},  rd_shift[7:0]};
      RD_LBU:  rd_result = {56'd0,              rd_shift[7:0]};
      RD_LH:   rd_result = {{48{rd_shift[15]}}, rd_shift[15:0]};
      RD_LHU:  rd_result = {48'd0,              rd_shift[15:0]};
      RD_LW:   rd_result = {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: rd_result = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      rd_q    <= RD_NONE;
      wr_q    <= WR_NONE;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    arr_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d = dram_addr;
          din_d  = dram_din;
          rd_d   = rd_in;
          wr_d   = wr_in;
          cnt_d  = CNT_W'(LATENCY - 1);
          if (req_err) begin
            state_d = ERROR;
            if (rd_in != RD_NONE) dout_d = '0;
          end else if (rd_in != RD_NONE) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
          end
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          dout_d  = rd_result;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE: begin
        if (cnt_q == '0) begin
          arr_we  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ERROR: state_d = IDLE;
    endcase
  end

  // A reset coinciding with the commit cycle drops the write
  dram_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (arr_we & ~rst),
    .be    (arr_be),
    .addr  (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  assign dram_dout = dout_q;
  assign state     = state_q;

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 Parameter DEPTH, 4096, number of 64-bit words in the backing array (power of two).
REQ-002 Parameter LATENCY, 4, busy cycles per access (1..15).
REQ-003 Parameter BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 dram_addr  in  64  byte address of request.
REQ-007 dram_din  in  64  write data, right-aligned (bits [7:0] hold a byte store).
REQ-008 dram_rd_ctrl  in  3  read op: 000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, 110 ld, 111 reserved.
REQ-009 dram_wr_ctrl  in  3  write op: 000 none, 001 sb, 010 sh, 011 sw, 100 sd, 101-111 reserved.
REQ-010 dram_dout  out  64  read result, right-aligned and extended.
REQ-011 state  out  2  00 IDLE/ready, 01 READ busy, 10 WRITE busy, 11 ERROR.

Function
REQ-012 Requests SHALL be accepted only in a cycle where state==IDLE and rd_ctrl or wr_ctrl is nonzero; addr, din, and op SHALL be latched at acceptance, and later input changes SHALL be ignored until IDLE returns.
REQ-013 Accepted read SHALL enter READ with a down-counter loaded to LATENCY-1; at counter 0 the array word SHALL be read, dram_dout SHALL be registered, and state SHALL return to IDLE; total accept-to-IDLE is exactly LATENCY cycles.
REQ-014 Accepted write SHALL enter WRITE with the same counter; at counter 0 the byte-enabled array write SHALL commit, and state SHALL return to IDLE after LATENCY cycles.
REQ-015 dram_dout SHALL hold its value until the next read completes; writes and errors SHALL NOT change it, except an ERROR on a read SHALL set it to 0.
REQ-016 Word index SHALL be (addr-BASE_ADDR)>>3; byte lane SHALL be addr[2:0]; a read SHALL extract size bytes from the lane; lb/lh/lw SHALL sign-extend, lbu/lhu SHALL zero-extend, and ld SHALL return the full word.
REQ-017 Write SHALL update only the size bytes starting at addr[2:0], taken from din low bytes; other bytes SHALL be unchanged.
REQ-018 ERROR SHALL be taken instead of READ/WRITE when any of the following holds: rd and wr both nonzero; reserved encoding; misaligned access (h:addr[0]!=0, w:addr[1:0]!=0, d:addr[2:0]!=0); addr<BASE_ADDR; or addr>=BASE_ADDR+8*DEPTH.
REQ-019 ERROR SHALL last exactly one cycle, then IDLE, with no array access; a request held through ERROR SHALL be re-evaluated in the following IDLE cycle.
REQ-020 Back-to-back: a new request present in the IDLE cycle after completion SHALL be accepted in that same cycle; sustained throughput is one access per LATENCY+1 cycles.
REQ-021 With LATENCY=1, state SHALL be busy for exactly one cycle per access.

Reset
REQ-022 On rst (sampled at posedge), state SHALL become IDLE, dram_dout 0, and the counter 0; an in-flight write SHALL be aborted uncommitted.
REQ-023 Array contents SHALL NOT be cleared by reset; initial contents are undefined, optionally preloaded by simulation only.

Structure
REQ-024 Package dram_pkg SHALL hold the state enum (IDLE/READ/WRITE/ERROR), the rd/wr op encodings, and BASE_ADDR default; the cache side SHALL import the same package.
REQ-025 One sub-module dram_array SHALL exist: single-port DEPTH x 64 synchronous-write array with 8-bit byte enables and combinational read; all protocol logic SHALL stay in dram_ctrl.

Verification
REQ-026 Test sd 0x8000_0010 din=0x1122334455667788, then ld the same address: state 10 for 4 cycles -> 00, then 01 for 4 cycles -> 00, dout=0x1122334455667788.
REQ-027 Test lb 0x8000_0017 after REQ-026: dout=0x0000000000000011; lb 0x8000_0010 when byte=0x88: dout=0xFFFFFFFFFFFFFF88; lbu: 0x88.
REQ-028 Test sh 0x8000_0012 din=0xBEEF over REQ-026 data, then ld: dout=0x11223344BEEF7788.
REQ-029 Test sw 0x8000_0002 -> state 11 one cycle, array unchanged; ld 0x7FFF_FFF8 -> 11 and dout=0; rd=110 with wr=100 together -> 11.
REQ-030 Test sd 0x8000_0020 with rst asserted in the 2nd WRITE cycle -> state 00 and dout=0 next cycle; subsequent ld 0x8000_0020 returns prior contents.
REQ-031 Test eight back-to-back ld at 0x8000_0040+8k held as the cache does (advance on state==00) -> each completes in 4 busy cycles and returns the correct word in order.
